mem_access_stage: RTL and testbench

- Memory stage of the multi-cycle RISC-V core. It sits between the EX/MEM pipeline register and MEM_WB_PIPELINE.
- Takes ALU result, store data and control from EX/MEM. Performs load/store over a req/ack data-memory bus with byte-lane alignment and sign-extension.
- Presents registered rd_data, addr, control and rd index to MEM_WB_PIPELINE.
- Stalls upstream through in_ready while a bus access is outstanding.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_access_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM states and
// writeback control bit positions.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_TO_REG = 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 64-bit data bus: store strobes and data shifts,
// load extraction with sign/zero extension, and natural-alignment check.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_LEN = 64,
  parameter int STRB_LEN = DATA_LEN / 8
) (
  input  logic [2:0]          funct3,
  input  logic [2:0]          lane,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic [DATA_LEN-1:0] rdata,
  output logic [STRB_LEN-1:0] wstrb,
  output logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] rd_ext,
  output logic                misalign
);

  logic [DATA_LEN-1:0] shifted;
  logic [STRB_LEN-1:0] strb_base;
  logic [5:0]          bit_sh;

  assign bit_sh = {lane, 3'b000};

  always_comb begin
    shifted = rdata >> bit_sh;
    rd_ext  = shifted;
    case (funct3)
      F3_B:  rd_ext = {{(DATA_LEN-8){shifted[7]}},   shifted[7:0]};
      F3_H:  rd_ext = {{(DATA_LEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:  rd_ext = {{(DATA_LEN-32){shifted[31]}}, shifted[31:0]};
      F3_BU: rd_ext = {{(DATA_LEN-8){1'b0}},  shifted[7:0]};
      F3_HU: rd_ext = {{(DATA_LEN-16){1'b0}}, shifted[15:0]};
      F3_WU: rd_ext = {{(DATA_LEN-32){1'b0}}, shifted[31:0]};
      default: rd_ext = shifted;  // LD and the unused 111 code
    endcase
  end

  always_comb begin
    strb_base = '0;
    misalign  = 1'b0;
    case (funct3[1:0])
      2'b00: strb_base = STRB_LEN'(8'h01);
      2'b01: begin strb_base = STRB_LEN'(8'h03); misalign = lane[0];      end
      2'b10: begin strb_base = STRB_LEN'(8'h0F); misalign = |lane[1:0];   end
      default: begin strb_base = STRB_LEN'(8'hFF); misalign = |lane;      end
    endcase
    wstrb = strb_base << lane;
    wdata = wr_data << bit_sh;
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/ack data-memory access with lane alignment, one-cycle out_valid.
// Optional MEM_TIMEOUT_EN adds a 255-cycle ack watchdog and a bus_err output.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_LEN         = 64,
  parameter int CONTROL_LINE     = 2,
  parameter int INSTRUCTION_PART = 5,
  parameter int STRB_LEN         = DATA_LEN / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        mem_read,
  input  logic                        mem_write,
  input  logic [2:0]                  funct3,
  input  logic [DATA_LEN-1:0]         addr,
  input  logic [DATA_LEN-1:0]         wr_data,
  input  logic [CONTROL_LINE-1:0]     control_in,
  input  logic [INSTRUCTION_PART-1:0] instruction_part,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [DATA_LEN-1:0]         dmem_addr,
  output logic [DATA_LEN-1:0]         dmem_wdata,
  output logic [STRB_LEN-1:0]         dmem_wstrb,
  input  logic                        dmem_ack,
  input  logic [DATA_LEN-1:0]         dmem_rdata,
  output logic                        out_valid,
  output logic [DATA_LEN-1:0]         rd_data,
  output logic [DATA_LEN-1:0]         addr_out,
  output logic [CONTROL_LINE-1:0]     control_out,
  output logic [INSTRUCTION_PART-1:0] instruction_part_out,
  output logic                        misalign
`ifdef MEM_TIMEOUT_EN
  ,
  output logic                        bus_err
`endif
);

  state_e state_q, state_d;

  // Latched operation
  logic [DATA_LEN-1:0]         addr_q, wdata_q;
  logic [2:0]                  f3_q;
  logic                        load_q, store_q;
  logic [CONTROL_LINE-1:0]     ctrl_q;
  logic [INSTRUCTION_PART-1:0] rd_q;

  // Registered results
  logic                        out_valid_q;
  logic [DATA_LEN-1:0]         rd_data_q, addr_out_q;
  logic [CONTROL_LINE-1:0]     ctrl_out_q;
  logic [INSTRUCTION_PART-1:0] rd_out_q;
  logic                        misalign_q;

  logic                        fin;
  logic [DATA_LEN-1:0]         res_rd_data, res_addr;
  logic [CONTROL_LINE-1:0]     res_ctrl;
  logic [INSTRUCTION_PART-1:0] res_rd;
  logic                        res_mis, res_err;

  logic [2:0]          al_f3, al_lane;
  logic [STRB_LEN-1:0] al_wstrb;
  logic [DATA_LEN-1:0] al_wdata, al_rd_ext;
  logic                al_mis;
  logic                accept;

  // Alignment is checked on the live inputs in IDLE, then on the latched op.
  assign accept  = (state_q == IDLE) && in_valid;
  assign al_f3   = (state_q == IDLE) ? funct3    : f3_q;
  assign al_lane = (state_q == IDLE) ? addr[2:0] : addr_q[2:0];

  mem_lane_align #(.DATA_LEN(DATA_LEN), .STRB_LEN(STRB_LEN)) u_align (
    .funct3   (al_f3),
    .lane     (al_lane),
    .wr_data  (wdata_q),
    .rdata    (dmem_rdata),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .rd_ext   (al_rd_ext),
    .misalign (al_mis)
  );

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wd_q;
  logic       bus_err_q;
  logic       timeout;
  assign timeout = (wd_q == 8'hFE);
  assign bus_err = bus_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == ACCESS) ? wd_q + 8'd1 : '0;
      if (fin) bus_err_q <= res_err;
    end
  end
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    fin         = 1'b0;
    res_rd_data = '0;
    res_addr    = addr_q;
    res_ctrl    = ctrl_q;
    res_rd      = rd_q;
    res_mis     = 1'b0;
    res_err     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        res_addr = addr;
        res_rd   = instruction_part;
        res_ctrl = control_in;
        if (in_valid) begin
          if ((mem_read || mem_write) && !al_mis) begin
            state_d = ACCESS;
          end else begin
            state_d = DONE;
            fin     = 1'b1;
            if (mem_read || mem_write) begin
              res_ctrl = '0;
              res_mis  = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d     = DONE;
          fin         = 1'b1;
          res_rd_data = load_q ? al_rd_ext : '0;
        end else if (timeout) begin
          state_d  = DONE;
          fin      = 1'b1;
          res_ctrl = '0;
          res_err  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      ctrl_q      <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      rd_data_q   <= '0;
      addr_out_q  <= '0;
      ctrl_out_q  <= '0;
      rd_out_q    <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= fin;
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wr_data;
        f3_q    <= funct3;
        load_q  <= mem_read;
        store_q <= mem_write && !mem_read;
        ctrl_q  <= control_in;
        rd_q    <= instruction_part;
      end
      if (fin) begin
        rd_data_q  <= res_rd_data;
        addr_out_q <= res_addr;
        ctrl_out_q <= res_ctrl;
        rd_out_q   <= res_rd;
        misalign_q <= res_mis;
      end
    end
  end

  assign dmem_req             = (state_q == ACCESS);
  assign dmem_we              = dmem_req && store_q;
  assign dmem_addr            = {addr_q[DATA_LEN-1:3], 3'b000};
  assign dmem_wdata           = dmem_we ? al_wdata : '0;
  assign dmem_wstrb           = dmem_we ? al_wstrb : '0;
  assign out_valid            = out_valid_q;
  assign rd_data              = rd_data_q;
  assign addr_out             = addr_out_q;
  assign control_out          = ctrl_out_q;
  assign instruction_part_out = rd_out_q;
  assign misalign             = misalign_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: non-memory ops, loads, stores,
// misaligned accesses, stray acks and reset during an access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [63:0] addr, wr_data;
  logic [1:0]  control_in, control_out;
  logic [4:0]  instruction_part, instruction_part_out;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        out_valid, misalign;
  logic [63:0] rd_data, addr_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wr_data(wr_data), .control_in(control_in),
    .instruction_part(instruction_part),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .rd_data(rd_data), .addr_out(addr_out),
    .control_out(control_out), .instruction_part_out(instruction_part_out),
    .misalign(misalign)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] ctl, input logic [4:0] rdi);
    in_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
    addr = a; wr_data = wd; control_in = ctl; instruction_part = rdi;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0;
    addr = '0; wr_data = '0; control_in = '0; instruction_part = '0;
    #23;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_addr_out", addr_out, 64'd0);
    chk("rst_misalign", 64'(misalign), 64'd0);
    rst = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Non-memory op
    issue(1'b0, 1'b0, 3'b000, 64'h1234, 64'h0, 2'b01, 5'd5);
    step(); idle_inputs();
    chk("nm_out_valid", 64'(out_valid), 64'd1);
    chk("nm_addr_out", addr_out, 64'h1234);
    chk("nm_rd_data", rd_data, 64'd0);
    chk("nm_ctrl", 64'(control_out), 64'd1);
    chk("nm_rd", 64'(instruction_part_out), 64'd5);
    chk("nm_req", 64'(dmem_req), 64'd0);
    chk("nm_in_ready_done", 64'(in_ready), 64'd0);
    step();
    chk("nm_pulse_end", 64'(out_valid), 64'd0);
    chk("nm_hold_addr", addr_out, 64'h1234);

    // LB at 0x1003, ack on the third access cycle
    issue(1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 2'b11, 5'd7);
    step(); idle_inputs();
    chk("lb_req", 64'(dmem_req), 64'd1);
    chk("lb_addr", dmem_addr, 64'h1000);
    chk("lb_we", 64'(dmem_we), 64'd0);
    chk("lb_in_ready", 64'(in_ready), 64'd0);
    step();
    step();
    chk("lb_req_held", 64'(dmem_req), 64'd1);
    chk("lb_no_valid", 64'(out_valid), 64'd0);
    dmem_ack = 1'b1; dmem_rdata = 64'h0000_0000_8000_0000;
    step(); dmem_ack = 1'b0;
    chk("lb_out_valid", 64'(out_valid), 64'd1);
    chk("lb_rd_data", rd_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_ctrl", 64'(control_out), 64'd3);
    chk("lb_rd", 64'(instruction_part_out), 64'd7);
    chk("lb_req_dropped", 64'(dmem_req), 64'd0);
    step();

    // LWU at 0x2004
    issue(1'b1, 1'b0, 3'b110, 64'h2004, 64'h0, 2'b11, 5'd8);
    step(); idle_inputs();
    dmem_ack = 1'b1; dmem_rdata = 64'h8765_4321_0000_0000;
    step(); dmem_ack = 1'b0;
    chk("lwu_rd_data", rd_data, 64'h0000_0000_8765_4321);
    chk("lwu_addr_out", addr_out, 64'h2004);
    step();

    // SH at 0x3002
    issue(1'b0, 1'b1, 3'b001, 64'h3002, 64'hABCD, 2'b00, 5'd0);
    step(); idle_inputs();
    chk("sh_we", 64'(dmem_we), 64'd1);
    chk("sh_wstrb", 64'(dmem_wstrb), 64'h0C);
    chk("sh_wdata", dmem_wdata, 64'h0000_0000_ABCD_0000);
    chk("sh_addr", dmem_addr, 64'h3000);
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); dmem_ack = 1'b0;
    chk("sh_out_valid", 64'(out_valid), 64'd1);
    chk("sh_rd_data", rd_data, 64'd0);
    step();

    // Misaligned LW at 0x4002
    issue(1'b1, 1'b0, 3'b010, 64'h4002, 64'h0, 2'b11, 5'd9);
    #1;
    chk("mis_req_idle", 64'(dmem_req), 64'd0);
    step(); idle_inputs();
    chk("mis_req", 64'(dmem_req), 64'd0);
    chk("mis_flag", 64'(misalign), 64'd1);
    chk("mis_ctrl", 64'(control_out), 64'd0);
    chk("mis_out_valid", 64'(out_valid), 64'd1);
    step();
    chk("mis_sticky", 64'(misalign), 64'd1);

    // Stray ack in IDLE is ignored
    dmem_ack = 1'b1;
    step(); dmem_ack = 1'b0;
    chk("stray_ack_valid", 64'(out_valid), 64'd0);
    chk("stray_ack_ready", 64'(in_ready), 64'd1);

    // LH at lane 6 with sign bit set; clears misalign
    issue(1'b1, 1'b0, 3'b001, 64'h6006, 64'h0, 2'b11, 5'd10);
    step(); idle_inputs();
    dmem_ack = 1'b1; dmem_rdata = 64'h8001_0000_0000_0000;
    step(); dmem_ack = 1'b0;
    chk("lh_rd_data", rd_data, 64'hFFFF_FFFF_FFFF_8001);
    chk("lh_mis_clear", 64'(misalign), 64'd0);
    step();

    // Read and write both set: behaves as LD
    issue(1'b1, 1'b1, 3'b011, 64'h7000, 64'h5555, 2'b11, 5'd11);
    step(); idle_inputs();
    chk("rw_we", 64'(dmem_we), 64'd0);
    chk("rw_wstrb", 64'(dmem_wstrb), 64'h00);
    dmem_ack = 1'b1; dmem_rdata = 64'hDEAD_BEEF_0123_4567;
    step(); dmem_ack = 1'b0;
    chk("rw_rd_data", rd_data, 64'hDEAD_BEEF_0123_4567);
    step();

    // SD strobes
    issue(1'b0, 1'b1, 3'b011, 64'h8000, 64'h1122_3344_5566_7788, 2'b00, 5'd0);
    step(); idle_inputs();
    chk("sd_wstrb", 64'(dmem_wstrb), 64'hFF);
    chk("sd_wdata", dmem_wdata, 64'h1122_3344_5566_7788);
    dmem_ack = 1'b1;
    step(); dmem_ack = 1'b0;
    step();

    // Reset during an access
    issue(1'b1, 1'b0, 3'b011, 64'h9000, 64'h0, 2'b11, 5'd12);
    step(); idle_inputs();
    chk("rm_req_before", 64'(dmem_req), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rm_req_dropped", 64'(dmem_req), 64'd0);
    chk("rm_in_ready", 64'(in_ready), 64'd1);
    step();
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 64'hFFFF;
    step(); dmem_ack = 1'b0;
    chk("rm_late_ack_valid", 64'(out_valid), 64'd0);
    chk("rm_rd_data", rd_data, 64'd0);
    step();
    chk("rm_late_ack_valid2", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
